// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer.
//   state_t         : sequencer FSM states
//   SAR_WIDTH       : result width of the SAR control block
//   DEFAULT_TIMEOUT : default go-to-completion limit in cycles
package sar_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIGGER,
        WAIT_CLEAR,
        WAIT_DONE,
        OUTPUT,
        PAUSE
    } state_t;

    localparam int SAR_WIDTH       = 16;
    localparam int DEFAULT_TIMEOUT = 64;

endpackage

// File: rtl/sar_seq_downcounter.sv
// Loadable down-counter with a zero flag. Load has priority over
// decrement; decrementing stops at zero instead of wrapping.
//   clk        : clock
//   reset      : synchronous active-high reset (count -> 0)
//   load       : load load_value this cycle
//   load_value : value to load
//   dec        : decrement by one this cycle (ignored when zero)
//   zero       : current count is zero
module sar_seq_downcounter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_reg;
    logic [W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load) begin
            count_next = load_value;
        end else if (dec && (count_reg != '0)) begin
            count_next = count_reg - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sar_conversion_sequencer.sv
// Initiator for the SAR go/valid/result handshake. Triggers 2^LOG2_AVG
// conversions back to back (each bounded by a timeout), averages them by
// truncation and offers the result on a valid/ready stream, then waits
// a programmable idle interval before the next batch.
//   clk, reset             : clock, synchronous active-high reset
//   enable                 : allow new batches (checked in IDLE only)
//   interval               : idle cycles between a transfer and next batch
//   err_clear              : clears the sticky err flag
//   sar_go                 : one-cycle conversion request
//   sar_valid, sar_result  : SAR completion level and result
//   out_data, out_valid,
//   out_ready              : averaged result stream
//   busy                   : FSM not in IDLE
//   err                    : sticky timeout flag
//   conv_idx               : conversions completed in current batch
import sar_pkg::*;

module sar_conversion_sequencer #(
    parameter int WIDTH    = SAR_WIDTH,
    parameter int LOG2_AVG = 2,
    parameter int TIMEOUT  = DEFAULT_TIMEOUT,
    parameter int IVL_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [IVL_W-1:0]    interval,
    input  logic                err_clear,
    output logic                sar_go,
    input  logic                sar_valid,
    input  logic [WIDTH-1:0]    sar_result,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy,
    output logic                err,
    output logic [LOG2_AVG:0]   conv_idx
);

    localparam int ACC_W = WIDTH + LOG2_AVG;
    localparam int CNT_W = LOG2_AVG + 1;
    localparam int TO_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] BATCH = CNT_W'(2 ** LOG2_AVG);

    state_t               state_reg, state_next;
    logic [ACC_W-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0]     conv_idx_reg, conv_idx_next;
    logic [WIDTH-1:0]     out_data_reg, out_data_next;
    logic                 err_reg, err_next;
    logic                 sar_go_reg, out_valid_reg, busy_reg;

    logic                 timeout;
    logic                 to_load, to_dec, to_zero;
    logic                 ivl_load, ivl_dec, ivl_zero;
    logic [IVL_W-1:0]     ivl_load_value;

    // The timeout counter is loaded on entry to TRIGGER and runs through
    // TRIGGER and both wait states, so it reaches zero in the cycle before
    // err becomes visible: err rises exactly TIMEOUT cycles after sar_go.
    assign to_load = (state_next == TRIGGER);
    assign to_dec  = (state_reg == TRIGGER) || (state_reg == WAIT_CLEAR) ||
                     (state_reg == WAIT_DONE);

    sar_seq_downcounter #(.W(TO_W)) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (to_load),
        .load_value (TO_W'(TIMEOUT - 1)),
        .dec        (to_dec),
        .zero       (to_zero)
    );

    // Loaded with interval-1 so PAUSE lasts exactly interval cycles
    // (IDLE adds one more before the next TRIGGER).
    sar_seq_downcounter #(.W(IVL_W)) u_interval_cnt (
        .clk        (clk),
        .reset      (reset),
        .load       (ivl_load),
        .load_value (ivl_load_value),
        .dec        (ivl_dec),
        .zero       (ivl_zero)
    );

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        conv_idx_next  = conv_idx_reg;
        out_data_next  = out_data_reg;
        timeout        = 1'b0;
        ivl_load       = 1'b0;
        ivl_load_value = '0;
        ivl_dec        = 1'b0;

        case (state_reg)
            IDLE: begin
                acc_next      = '0;
                conv_idx_next = '0;
                if (enable && !err_reg) begin
                    state_next = TRIGGER;
                end
            end
            TRIGGER: begin
                state_next = WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
                if (to_zero) begin
                    timeout = 1'b1;
                end else if (!sar_valid) begin
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // valid was seen low in WAIT_CLEAR, so a high level here is
                // the rising edge of this conversion's completion.
                if (to_zero) begin
                    timeout = 1'b1;
                end else if (sar_valid) begin
                    acc_next      = acc_reg + ACC_W'(sar_result);
                    conv_idx_next = conv_idx_reg + CNT_W'(1);
                    if (conv_idx_next == BATCH) begin
                        out_data_next = acc_next[ACC_W-1:LOG2_AVG];
                        state_next    = OUTPUT;
                    end else begin
                        state_next = TRIGGER;
                    end
                end
            end
            OUTPUT: begin
                if (out_ready) begin
                    if ((interval == '0) && enable) begin
                        state_next = IDLE;
                    end else begin
                        state_next     = PAUSE;
                        ivl_load       = 1'b1;
                        ivl_load_value = (interval == '0) ? '0 : interval - IVL_W'(1);
                    end
                end
            end
            PAUSE: begin
                if (ivl_zero) begin
                    state_next = IDLE;
                end else begin
                    ivl_dec = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (timeout) begin
            state_next = IDLE;
        end

        // Setting the flag beats a simultaneous clear.
        if (timeout) begin
            err_next = 1'b1;
        end else if (err_clear) begin
            err_next = 1'b0;
        end else begin
            err_next = err_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            conv_idx_reg  <= '0;
            out_data_reg  <= '0;
            err_reg       <= 1'b0;
            sar_go_reg    <= 1'b0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            conv_idx_reg  <= conv_idx_next;
            out_data_reg  <= out_data_next;
            err_reg       <= err_next;
            sar_go_reg    <= (state_next == TRIGGER);
            out_valid_reg <= (state_next == OUTPUT);
            busy_reg      <= (state_next != IDLE);
        end
    end

    assign sar_go    = sar_go_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;
    assign conv_idx  = conv_idx_reg;

endmodule

// File: tb/tb_sar_conversion_sequencer.sv
// Directed testbench for sar_conversion_sequencer with a behavioural SAR
// block that completes each conversion SAR_C cycles after seeing sar_go.
module tb_sar_conversion_sequencer;

    localparam int WIDTH    = 16;
    localparam int LOG2_AVG = 2;
    localparam int TIMEOUT  = 64;
    localparam int IVL_W    = 16;
    localparam int SAR_C    = 3;

    logic                clk        = 1'b0;
    logic                reset      = 1'b1;
    logic                enable     = 1'b0;
    logic [IVL_W-1:0]    interval   = '0;
    logic                err_clear  = 1'b0;
    logic                sar_go;
    logic                sar_valid;
    logic [WIDTH-1:0]    sar_result;
    logic [WIDTH-1:0]    out_data;
    logic                out_valid;
    logic                out_ready  = 1'b0;
    logic                busy;
    logic                err;
    logic [LOG2_AVG:0]   conv_idx;

    int vectors     = 0;
    int miscompares = 0;

    // SAR model state
    logic [WIDTH-1:0] res_tab [4];
    logic [1:0]       res_i;
    int               sar_cnt;
    bit               sar_hang = 1'b0;

    int go_count   = 0;
    int xfer_count = 0;

    always #5 clk = ~clk;

    sar_conversion_sequencer #(
        .WIDTH    (WIDTH),
        .LOG2_AVG (LOG2_AVG),
        .TIMEOUT  (TIMEOUT),
        .IVL_W    (IVL_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .interval   (interval),
        .err_clear  (err_clear),
        .sar_go     (sar_go),
        .sar_valid  (sar_valid),
        .sar_result (sar_result),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy),
        .err        (err),
        .conv_idx   (conv_idx)
    );

    // Behavioural SAR: drops valid on go, raises it with the next table
    // entry SAR_C cycles later; shares the reset net with the DUT.
    always @(posedge clk) begin
        if (reset) begin
            sar_valid  <= 1'b0;
            sar_result <= '0;
            sar_cnt    <= 0;
            res_i      <= '0;
        end else if (sar_go) begin
            sar_valid <= 1'b0;
            sar_cnt   <= sar_hang ? 0 : SAR_C;
        end else if (sar_cnt != 0) begin
            sar_cnt <= sar_cnt - 1;
            if (sar_cnt == 1) begin
                sar_valid  <= 1'b1;
                sar_result <= res_tab[res_i];
                res_i      <= res_i + 2'd1;
            end
        end
    end

    always @(posedge clk) begin
        if (sar_go) go_count <= go_count + 1;
        if (out_valid && out_ready) xfer_count <= xfer_count + 1;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_go(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sar_go) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic run_batch(output bit ok);
        enable = 1'b1;
        wait_valid(ok);
        enable = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++; if (sar_go !== 1'b0) begin miscompares++; $display("FAIL rst_sar_go: got %b expected 0", sar_go); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        vectors++; if (out_data !== 16'd0) begin miscompares++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err: got %b expected 0", err); end
        vectors++; if (conv_idx !== 3'd0) begin miscompares++; $display("FAIL rst_conv_idx: got %0d expected 0", conv_idx); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b expected 0", busy); end
        $display("test_reset done");
    endtask

    task automatic test_average();
        bit ok;
        int g0, x0, n;
        res_tab = '{16'd100, 16'd200, 16'd300, 16'd400};
        interval = '0;
        out_ready = 1'b0;
        g0 = go_count;
        x0 = xfer_count;
        enable = 1'b1;
        wait_go(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL avg_first_go: got none expected sar_go"); end
        n = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) break;
        end
        enable = 1'b0;
        vectors++; if (n != 4 * (SAR_C + 2)) begin miscompares++; $display("FAIL avg_latency: got %0d expected %0d", n, 4 * (SAR_C + 2)); end
        vectors++; if (out_data !== 16'd250) begin miscompares++; $display("FAIL avg_data: got %0d expected 250", out_data); end
        vectors++; if (conv_idx !== 3'd4) begin miscompares++; $display("FAIL avg_conv_idx: got %0d expected 4", conv_idx); end
        vectors++; if (go_count - g0 != 4) begin miscompares++; $display("FAIL avg_go_count: got %0d expected 4", go_count - g0); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL avg_busy: got %b expected 1", busy); end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL avg_valid_drop: got %b expected 0", out_valid); end
        repeat (10) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL avg_idle: got %b expected 0", busy); end
        vectors++; if (go_count - g0 != 4) begin miscompares++; $display("FAIL avg_go_after: got %0d expected 4", go_count - g0); end
        vectors++; if (xfer_count - x0 != 1) begin miscompares++; $display("FAIL avg_xfers: got %0d expected 1", xfer_count - x0); end
        $display("test_average done: out_data=%0d", out_data);
    endtask

    task automatic test_truncation();
        bit ok;
        res_tab = '{16'd1, 16'd1, 16'd1, 16'd2};
        run_batch(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL trunc_timeout: got none expected out_valid"); end
        vectors++; if (out_data !== 16'd1) begin miscompares++; $display("FAIL trunc_data: got %0d expected 1", out_data); end
        drain();
        res_tab = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        run_batch(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL max_timeout: got none expected out_valid"); end
        vectors++; if (out_data !== 16'hFFFF) begin miscompares++; $display("FAIL max_data: got %0h expected ffff", out_data); end
        drain();
        $display("test_truncation done");
    endtask

    task automatic test_backpressure();
        bit ok;
        int x0;
        res_tab = '{16'd10, 16'd20, 16'd30, 16'd40};
        x0 = xfer_count;
        run_batch(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL bp_timeout: got none expected out_valid"); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL bp_valid_hold: cycle %0d got %b expected 1", i, out_valid); end
            vectors++; if (out_data !== 16'd25) begin miscompares++; $display("FAIL bp_data_hold: cycle %0d got %0d expected 25", i, out_data); end
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_valid_drop: got %b expected 0", out_valid); end
        repeat (5) @(negedge clk);
        vectors++; if (xfer_count - x0 != 1) begin miscompares++; $display("FAIL bp_xfers: got %0d expected 1", xfer_count - x0); end
        $display("test_backpressure done");
    endtask

    task automatic test_interval();
        bit ok;
        int x0, n, extra;
        res_tab = '{16'd100, 16'd200, 16'd300, 16'd400};
        interval = 16'd5;
        out_ready = 1'b1;
        x0 = xfer_count;
        enable = 1'b1;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ivl_timeout: got none expected out_valid"); end
        n = 0;
        extra = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (out_valid) extra++;
            if (sar_go) break;
        end
        vectors++; if (n != 7) begin miscompares++; $display("FAIL ivl_gap: got %0d expected 7", n); end
        vectors++; if (extra != 0) begin miscompares++; $display("FAIL ivl_valid_once: got %0d extra expected 0", extra); end
        enable = 1'b0;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL ivl_timeout2: got none expected out_valid"); end
        vectors++; if (out_data !== 16'd250) begin miscompares++; $display("FAIL ivl_data: got %0d expected 250", out_data); end
        repeat (12) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL ivl_idle: got %b expected 0", busy); end
        vectors++; if (xfer_count - x0 != 2) begin miscompares++; $display("FAIL ivl_xfers: got %0d expected 2", xfer_count - x0); end
        out_ready = 1'b0;
        interval = '0;
        $display("test_interval done");
    endtask

    task automatic test_back_to_back();
        bit ok;
        int n;
        res_tab = '{16'd100, 16'd200, 16'd300, 16'd400};
        interval = '0;
        out_ready = 1'b1;
        enable = 1'b1;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout: got none expected out_valid"); end
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (sar_go) break;
        end
        vectors++; if (n != 2) begin miscompares++; $display("FAIL b2b_gap: got %0d expected 2", n); end
        enable = 1'b0;
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL b2b_timeout2: got none expected out_valid"); end
        repeat (6) @(negedge clk);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle: got %b expected 0", busy); end
        out_ready = 1'b0;
        $display("test_back_to_back done");
    endtask

    task automatic test_enable_drop();
        bit ok;
        int g0;
        res_tab = '{16'd1000, 16'd2000, 16'd3000, 16'd4000};
        out_ready = 1'b0;
        g0 = go_count;
        enable = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (conv_idx == 3'd2) begin
                ok = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL en_two_conv: got none expected conv_idx 2"); end
        wait_valid(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL en_timeout: got none expected out_valid"); end
        vectors++; if (out_data !== 16'd2500) begin miscompares++; $display("FAIL en_data: got %0d expected 2500", out_data); end
        drain();
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL en_idle: got %b expected 0", busy); end
        vectors++; if (go_count - g0 != 4) begin miscompares++; $display("FAIL en_go_count: got %0d expected 4", go_count - g0); end
        $display("test_enable_drop done");
    endtask

    task automatic test_timeout();
        bit ok;
        int n, g1;
        sar_hang = 1'b1;
        out_ready = 1'b0;
        enable = 1'b1;
        wait_go(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL to_go: got none expected sar_go"); end
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            n++;
            if (err) break;
        end
        vectors++; if (n != TIMEOUT) begin miscompares++; $display("FAIL to_latency: got %0d expected %0d", n, TIMEOUT); end
        g1 = go_count;
        repeat (100) @(negedge clk);
        vectors++; if (go_count != g1) begin miscompares++; $display("FAIL to_no_go: got %0d expected 0 extra pulses", go_count - g1); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL to_busy: got %b expected 0", busy); end
        vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky: got %b expected 1", err); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL to_no_output: got %b expected 0", out_valid); end
        $display("test_timeout done");
    endtask

    task automatic test_err_clear();
        bit ok;
        int g0;
        sar_hang = 1'b0;
        res_tab = '{16'd100, 16'd200, 16'd300, 16'd400};
        g0 = go_count;
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL clr_err: got %b expected 0", err); end
        wait_go(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL clr_restart: got none expected sar_go"); end
        wait_valid(ok);
        enable = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL clr_timeout: got none expected out_valid"); end
        vectors++; if (out_data !== 16'd250) begin miscompares++; $display("FAIL clr_data: got %0d expected 250", out_data); end
        drain();
        vectors++; if (go_count - g0 != 4) begin miscompares++; $display("FAIL clr_go_count: got %0d expected 4", go_count - g0); end
        $display("test_err_clear done");
    endtask

    task automatic test_reset_mid();
        bit ok;
        res_tab = '{16'd100, 16'd200, 16'd300, 16'd400};
        out_ready = 1'b0;
        enable = 1'b1;
        wait_go(ok);
        wait_go(ok);
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_second_go: got none expected sar_go"); end
        repeat (2) @(negedge clk);
        vectors++; if (conv_idx !== 3'd1) begin miscompares++; $display("FAIL rm_conv_before: got %0d expected 1", conv_idx); end
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (sar_go !== 1'b0) begin miscompares++; $display("FAIL rm_sar_go: got %b expected 0", sar_go); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rm_busy: got %b expected 0", busy); end
        vectors++; if (conv_idx !== 3'd0) begin miscompares++; $display("FAIL rm_conv_idx: got %0d expected 0", conv_idx); end
        vectors++; if (out_data !== 16'd0) begin miscompares++; $display("FAIL rm_out_data: got %0d expected 0", out_data); end
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rm_out_valid: got %b expected 0", out_valid); end
        vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rm_err: got %b expected 0", err); end
        reset = 1'b0;
        wait_valid(ok);
        enable = 1'b0;
        vectors++; if (!ok) begin miscompares++; $display("FAIL rm_timeout: got none expected out_valid"); end
        vectors++; if (out_data !== 16'd250) begin miscompares++; $display("FAIL rm_data: got %0d expected 250", out_data); end
        vectors++; if (conv_idx !== 3'd4) begin miscompares++; $display("FAIL rm_conv_after: got %0d expected 4", conv_idx); end
        drain();
        $display("test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_average();
        test_truncation();
        test_backpressure();
        test_interval();
        test_back_to_back();
        test_enable_drop();
        test_timeout();
        test_err_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
